// File: rtl/sha_round_sequencer_pkg.sv
// ============================================================================
// Module  : sha_round_sequencer_pkg
// Purpose : Shared definitions for the SHA-256/SHA-512 round sequencer:
//           FSM state encodings and the standard round counts.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sha_round_sequencer_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sha_round_sequencer_ctr.sv
// ============================================================================
// Module  : sha_round_ctr
// Purpose : Round step counter. Advances by STEP each enabled cycle and
//           saturates at the terminal value i_lim (it never wraps).
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_clr         - synchronous clear to zero
//           i_en          - advance by STEP this cycle
//           i_lim         - terminal value (index of the last step)
//           o_cnt         - current count
//           o_term        - o_cnt == i_lim
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_round_ctr #(
    parameter int CNT_W = 7,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_lim,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == i_lim);

    // The last step leaves the count at the terminal value so the final
    // round index stays visible until the block is retired.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_term) begin
            r_cnt <= r_cnt + CNT_W'(STEP);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = w_term;

endmodule

`default_nettype wire

// File: rtl/sha_round_sequencer.sv
// ============================================================================
// Module  : sha_round_sequencer
// Purpose : Round sequencer for the SHA-256/SHA-512 compression core.
//           IDLE -> LOAD -> RUN -> FINAL -> DONE -> IDLE, with start/done
//           handshakes, stall, abort and UNROLL rounds per RUN cycle.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           start_valid/start_ready  - block start handshake
//           mode                     - 0=SHA-256, 1=SHA-512 (latched on start)
//           stall, abort             - freeze progress / cancel block
//           done_valid/done_ready    - block completion handshake
//           busy                     - sequencer not idle
//           load_en, round_en, final_en - datapath strobes
//           round, round_first, round_last - current step round index/flags
//           w_idx, w_sel_msg         - message-schedule window control
//           mode_q                   - mode of the block in flight
//           blk_cnt                  - completed block count (optional)
// Config  : SHA_SEQ_BLOCK_CNT_EN adds the 32-bit blk_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_round_sequencer
    import sha_round_sequencer_pkg::*;
#(
    parameter int CNT_W     = 7,
    parameter int ROUNDS0   = SHA256_ROUNDS,
    parameter int ROUNDS1   = SHA512_ROUNDS,
    parameter int UNROLL    = 1,
    parameter int WIN_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic                         mode,
    input  logic                         stall,
    input  logic                         abort,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic                         busy,
    output logic                         load_en,
    output logic                         round_en,
    output logic                         final_en,
    output logic [CNT_W-1:0]             round,
    output logic                         round_first,
    output logic                         round_last,
    output logic [$clog2(WIN_DEPTH)-1:0] w_idx,
    output logic                         w_sel_msg,
    output logic                         mode_q
`ifdef SHA_SEQ_BLOCK_CNT_EN
    ,
    output logic [31:0]                  blk_cnt
`endif
);

    localparam int         c_WIN_W = $clog2(WIN_DEPTH);
    localparam [CNT_W-1:0] c_LIM0  = CNT_W'(ROUNDS0 - UNROLL);
    localparam [CNT_W-1:0] c_LIM1  = CNT_W'(ROUNDS1 - UNROLL);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic             r_mode_q;
    logic             w_accept;
    logic             w_done_hs;
    logic             w_ctr_clr;
    logic [CNT_W-1:0] w_lim;
    logic [CNT_W-1:0] w_round;
    logic             w_term;

    // Abort blocks acceptance so a cancelled cycle can never start a block.
    assign start_ready = (r_state == ST_IDLE) && !abort;
    assign w_accept    = start_valid && start_ready;
    assign w_done_hs   = (r_state == ST_DONE) && done_ready && !abort;
    assign w_lim       = r_mode_q ? c_LIM1 : c_LIM0;

    // Round index returns to zero when a block ends (handshake or abort) and
    // again on accept, so LOAD always presents round 0.
    assign w_ctr_clr = abort || w_done_hs || w_accept;

    sha_round_ctr #(
        .CNT_W (CNT_W),
        .STEP  (UNROLL)
    ) u_round_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_ctr_clr),
        .i_en   (round_en),
        .i_lim  (w_lim),
        .o_cnt  (w_round),
        .o_term (w_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mode_q <= mode;
            end
        end
    end

    // Abort overrides everything (no strobe that cycle), then stall, then start.
    always_comb begin
        w_state_nxt = r_state;
        load_en     = 1'b0;
        round_en    = 1'b0;
        final_en    = 1'b0;
        done_valid  = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_en     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        round_en = 1'b1;
                        if (w_term) begin
                            w_state_nxt = ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (!stall) begin
                        final_en    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_valid = 1'b1;
                    if (done_ready) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign round       = w_round;
    assign round_first = round_en && (w_round == '0);
    assign round_last  = round_en && w_term;
    assign w_idx       = w_round[c_WIN_W-1:0];
    assign w_sel_msg   = (w_round < CNT_W'(WIN_DEPTH));
    assign mode_q      = r_mode_q;

`ifdef SHA_SEQ_BLOCK_CNT_EN
    logic [31:0] r_blk_cnt;

    // Only retired blocks count; the 32-bit add wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (w_done_hs) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha_round_sequencer.sv
// ============================================================================
// Module  : tb_sha_round_sequencer
// Purpose : Self-checking bench for sha_round_sequencer. The driver pushes
//           the expected strobe sequence (kind, cycle, round fields) into a
//           queue as each block is started; a negedge monitor pops and
//           compares on every strobe. A second instance with UNROLL=4 is
//           checked directly.
// Config  : honours SHA_SEQ_BLOCK_CNT_EN (blk_cnt checks).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha_round_sequencer;

    localparam int K_LOAD  = 1;
    localparam int K_ROUND = 2;
    localparam int K_FINAL = 3;
    localparam int K_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- UNROLL=1 instance ----------------
    logic       start_valid = 0, mode = 0, stall = 0, abort = 0, done_ready = 0;
    logic       start_ready, done_valid, busy, load_en, round_en, final_en;
    logic [6:0] round;
    logic       round_first, round_last, w_sel_msg, mode_q;
    logic [3:0] w_idx;
`ifdef SHA_SEQ_BLOCK_CNT_EN
    logic [31:0] blk_cnt;
`endif

    sha_round_sequencer #(.UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .mode(mode), .stall(stall), .abort(abort), .done_valid(done_valid),
        .done_ready(done_ready), .busy(busy), .load_en(load_en), .round_en(round_en),
        .final_en(final_en), .round(round), .round_first(round_first),
        .round_last(round_last), .w_idx(w_idx), .w_sel_msg(w_sel_msg), .mode_q(mode_q)
`ifdef SHA_SEQ_BLOCK_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    // ---------------- UNROLL=4 instance ----------------
    logic       sv4 = 0, m4 = 0, dr4 = 0;
    logic       sr4, dv4, busy4, ld4, re4, fe4, rf4, rl4, ws4, mq4;
    logic [6:0] round4;
    logic [3:0] widx4;
`ifdef SHA_SEQ_BLOCK_CNT_EN
    logic [31:0] blk_cnt4;
`endif

    sha_round_sequencer #(.UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
        .mode(m4), .stall(1'b0), .abort(1'b0), .done_valid(dv4),
        .done_ready(dr4), .busy(busy4), .load_en(ld4), .round_en(re4),
        .final_en(fe4), .round(round4), .round_first(rf4),
        .round_last(rl4), .w_idx(widx4), .w_sel_msg(ws4), .mode_q(mq4)
`ifdef SHA_SEQ_BLOCK_CNT_EN
        , .blk_cnt(blk_cnt4)
`endif
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int kind;
        int cyc;
        int rnd;
        bit first;
        bit last;
        int widx;
        bit wsel;
        bit mq;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int r, input bit mq, input int n);
        ev_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.rnd   = r;
        e.first = (r == 0);
        e.last  = (r == n - 1);
        e.widx  = r % 16;
        e.wsel  = (r < 16);
        e.mq    = mq;
        exp_q.push_back(e);
    endtask

    task automatic mon_evt(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe at cycle %0d: kind %0d, expected none", cyc, kind);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", kind, e.kind);
            chk("evt_cycle", cyc, e.cyc);
            if (kind == K_ROUND && e.kind == K_ROUND) begin
                chk("round", 32'(round), e.rnd);
                chk("round_first", 32'(round_first), 32'(e.first));
                chk("round_last", 32'(round_last), 32'(e.last));
                chk("w_idx", 32'(w_idx), e.widx);
                chk("w_sel_msg", 32'(w_sel_msg), 32'(e.wsel));
                chk("mode_q", 32'(mode_q), 32'(e.mq));
            end
        end
    endtask

    logic prev_dv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (load_en)                 mon_evt(K_LOAD);
            if (round_en)                mon_evt(K_ROUND);
            if (final_en)                mon_evt(K_FINAL);
            if (done_valid && !prev_dv)  mon_evt(K_DONE);
        end
        prev_dv = done_valid;
    end

    // ---------------- driver ----------------
    // stall_round/abort_round < 0 means none; hold_sv keeps start_valid high
    // for the whole block including the done handshake cycle.
    task automatic run_block(input bit m, input bit toggle, input int stall_round,
                             input int stall_len, input int abort_round,
                             input int ready_delay, input bit hold_sv);
        int n, t, s, a, c, d, h, last;
        n = m ? 80 : 64;
        @(posedge clk); #1;
        start_valid = 1'b1;
        mode        = m;
        stall       = 1'b0;
        abort       = 1'b0;
        done_ready  = 1'b0;
        @(negedge clk);
        chk("start_ready_at_start", 32'(start_ready), 32'd1);
        t = cyc;
        s = (stall_round >= 0) ? t + 2 + stall_round : -1000;
        a = (abort_round >= 0) ? t + 2 + abort_round : -1000;
        push_ev(K_LOAD, t + 1, 0, m, n);
        c = t + 2;
        for (int r = 0; r < n; r++) begin
            if (abort_round >= 0 && r == abort_round) break;
            if (r == stall_round) c += stall_len;
            push_ev(K_ROUND, c, r, m, n);
            c++;
        end
        d = c + 1;
        h = d + ready_delay;
        if (abort_round < 0) begin
            push_ev(K_FINAL, c, 0, m, n);
            push_ev(K_DONE, d, 0, m, n);
            last = h;
        end else begin
            last = a + 1;
        end
        for (int cc = t + 1; cc <= last; cc++) begin
            @(posedge clk); #1;
            if (!hold_sv) start_valid = 1'b0;
            if (toggle) mode = ~mode;
            stall      = (cc >= s) && (cc < s + stall_len);
            abort      = (cc == a);
            done_ready = (abort_round < 0) && (cc == h);
            @(negedge clk);
            if (cc >= s && cc < s + stall_len) begin
                chk("stall_round_hold", 32'(round), stall_round);
                chk("stall_round_en", 32'(round_en), 32'd0);
            end
            if (abort_round >= 0 && cc == a + 1) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_round", 32'(round), 32'd0);
                chk("abort_done_valid", 32'(done_valid), 32'd0);
            end
            if (abort_round < 0 && cc >= d && cc <= h) begin
                chk("done_held", 32'(done_valid), 32'd1);
                chk("start_ready_in_done", 32'(start_ready), 32'd0);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start_valid = 1'b0;
            done_ready  = 1'b0;
            stall       = 1'b0;
            abort       = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_mode_q", 32'(mode_q), 32'd0);
        chk("rst_strobes", 32'({load_en, round_en, final_en}), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
`ifdef SHA_SEQ_BLOCK_CNT_EN
        chk("rst_blk_cnt", blk_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        run_block(1'b0, 1'b0, -1, 0, -1, 0, 1'b0);   // SHA-256 baseline
        idle(2);
        run_block(1'b1, 1'b1, -1, 0, -1, 0, 1'b0);   // SHA-512, mode toggling while busy
        idle(2);
        run_block(1'b0, 1'b0, 20, 3, -1, 0, 1'b0);   // 3-cycle stall at round 20
        idle(2);
        run_block(1'b0, 1'b0, -1, 0, 40, 0, 1'b0);   // abort at round 40
        idle(3);
        run_block(1'b1, 1'b0, -1, 0, -1, 5, 1'b1);   // done_ready late, start held
        run_block(1'b0, 1'b0, -1, 0, -1, 0, 1'b0);   // back-to-back start
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef SHA_SEQ_BLOCK_CNT_EN
        chk("blk_cnt_total", blk_cnt, 32'd5);
`endif

        // UNROLL=4, SHA-512: 20 steps of 4 rounds.
`ifdef SHA_SEQ_BLOCK_CNT_EN
        chk("u4_blk_cnt_before", blk_cnt4, 32'd0);
`endif
        @(posedge clk); #1;
        sv4 = 1'b1;
        m4  = 1'b1;
        @(negedge clk);
        chk("u4_start_ready", 32'(sr4), 32'd1);
        @(posedge clk); #1;
        sv4   = 1'b0;
        steps = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (re4) begin
                chk("u4_round", 32'(round4), 32'(steps * 4));
                chk("u4_round_last", 32'(rl4), 32'(steps == 19));
                steps++;
            end
            if (dv4) break;
        end
        chk("u4_done_valid", 32'(dv4), 32'd1);
        chk("u4_steps", 32'(steps), 32'd20);
        @(posedge clk); #1;
        dr4 = 1'b1;
        @(posedge clk); #1;
        dr4 = 1'b0;
        @(negedge clk);
        chk("u4_idle_after", 32'(busy4), 32'd0);
`ifdef SHA_SEQ_BLOCK_CNT_EN
        chk("u4_blk_cnt_after", blk_cnt4, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
